vga_raster: RTL and testbench

Raster timing generator and pixel compositor for the pong display path. Free-running horizontal and vertical counters produce the `row`/`col` scan coordinates consumed by the ball and paddle blocks, sample their `*_present` replies, and drive registered, sync-aligned RGB and sync signals to the VGA DAC. Also emits a once-per-frame tick for game-logic pacing.

---
 rtl/vga_raster.sv | 130 +++++++++++++
 tb/tb_vga_raster.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vga_raster.sv
`default_nettype none
// ============================================================================
// Module   : vga_raster
// Purpose  : VGA raster counters, sync generation and registered pixel
//            compositor (ball > paddle > optional border > background).
//            Define VGA_BORDER_EN to draw an 8,8,8 frame on the active edge.
// Revision : 1.0
// ============================================================================
module vga_raster #(
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [$clog2(ACTIVE_ROWS)-1:0] row,
  output logic [$clog2(ACTIVE_COLS)-1:0] col,
  input  logic                           ball_present,
  input  logic                           paddle_present,
  output logic                           hsync,
  output logic                           vsync,
  output logic [3:0]                     vga_r,
  output logic [3:0]                     vga_g,
  output logic [3:0]                     vga_b,
  output logic                           frame_tick
);

  localparam int H_TOTAL = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int RW      = $clog2(ACTIVE_ROWS);
  localparam int CW      = $clog2(ACTIVE_COLS);

  // Window ends carry one extra bit so an end equal to the total never wraps.
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW:0]   H_ACT    = (HW+1)'(ACTIVE_COLS);
  localparam logic [HW:0]   HS_START = (HW+1)'(ACTIVE_COLS + H_FRONT);
  localparam logic [HW:0]   HS_END   = (HW+1)'(ACTIVE_COLS + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW:0]   V_ACT    = (VW+1)'(ACTIVE_ROWS);
  localparam logic [VW:0]   VS_START = (VW+1)'(ACTIVE_ROWS + V_FRONT);
  localparam logic [VW:0]   VS_END   = (VW+1)'(ACTIVE_ROWS + V_FRONT + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [HW:0]   h_ext;
  logic [VW:0]   v_ext;
  logic          active;
  logic          hs_win;
  logic          vs_win;
  logic [3:0]    pix_r;
  logic [3:0]    pix_g;
  logic [3:0]    pix_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign active = (h_ext < H_ACT) && (v_ext < V_ACT);
  assign hs_win = (h_ext >= HS_START) && (h_ext < HS_END);
  assign vs_win = (v_ext >= VS_START) && (v_ext < VS_END);

  assign row = active ? v_cnt[RW-1:0] : '0;
  assign col = active ? h_cnt[CW-1:0] : '0;

`ifdef VGA_BORDER_EN
  localparam logic [RW-1:0] R_LAST = RW'(ACTIVE_ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(ACTIVE_COLS - 1);
  logic border;
  assign border = (row == '0) || (row == R_LAST) || (col == '0) || (col == C_LAST);
`endif

  always_comb begin
    pix_r = 4'h0;
    pix_g = 4'h0;
    pix_b = 4'h0;
    if (active) begin
      if (ball_present) begin
        pix_r = 4'hF;
        pix_g = 4'hF;
        pix_b = 4'hF;
      end else if (paddle_present) begin
        pix_g = 4'hF;
`ifdef VGA_BORDER_EN
      end else if (border) begin
        pix_r = 4'h8;
        pix_g = 4'h8;
        pix_b = 4'h8;
`endif
      end
    end
  end

  // Single output stage keeps sync and colour aligned to the same counter value.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      vga_r      <= 4'h0;
      vga_g      <= 4'h0;
      vga_b      <= 4'h0;
      frame_tick <= 1'b0;
    end else begin
      hsync      <= ~hs_win;
      vsync      <= ~vs_win;
      vga_r      <= pix_r;
      vga_g      <= pix_g;
      vga_b      <= pix_b;
      frame_tick <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_raster.sv
`default_nettype none
// Scoreboard bench for vga_raster on a reduced raster; expectations come from
// the cycle index since reset release using plain division/modulo arithmetic.
module tb_vga_raster;

  localparam int AC = 16;
  localparam int AR = 12;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = AC + HF + HS + HB;
  localparam int VT = AR + VF + VS + VB;
  localparam int RW = $clog2(AR);
  localparam int CW = $clog2(AC);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ball = 1'b0;
  logic          paddle = 1'b0;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          hsync;
  logic          vsync;
  logic [3:0]    vga_r;
  logic [3:0]    vga_g;
  logic [3:0]    vga_b;
  logic          frame_tick;

  vga_raster #(
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .ball_present(ball), .paddle_present(paddle),
    .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hs;
    logic       vs;
    logic       tick;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  bit   quiet = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input int kk, input logic bp, input logic pp);
    exp_t e;
    int   h;
    int   v;
    bit   act;
    bit   edge_px;
    h       = kk % HT;
    v       = (kk / HT) % VT;
    act     = (h < AC) && (v < AR);
    edge_px = (h == 0) || (h == AC - 1) || (v == 0) || (v == AR - 1);
    e.hs    = !((h >= AC + HF) && (h < AC + HF + HS));
    e.vs    = !((v >= AR + VF) && (v < AR + VF + VS));
    e.tick  = (h == 0) && (v == 0);
    e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
    if (act && bp) begin
      e.r = 4'hF; e.g = 4'hF; e.b = 4'hF;
    end else if (act && pp) begin
      e.g = 4'hF;
    end else if (act && edge_px) begin
`ifdef VGA_BORDER_EN
      e.r = 4'h8; e.g = 4'h8; e.b = 4'h8;
`endif
    end
    return e;
  endfunction

  // Called just after a falling edge: checks scan coordinates, drives inputs
  // for this pixel and queues the response expected after the next rising edge.
  task automatic step();
    int   h;
    int   v;
    int   sel;
    bit   act;
    h   = k % HT;
    v   = (k / HT) % VT;
    act = (h < AC) && (v < AR);
    chk("row", 32'(row), act ? v : 0);
    chk("col", 32'(col), act ? h : 0);
    sel    = quiet ? 0 : int'($urandom_range(0, 3));
    ball   = sel[0];
    paddle = sel[1];
    sb.push_back(model(k, sel[0], sel[1]));
    @(negedge clk);
    k++;
  endtask

  task automatic check_reset_outputs();
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_rgb", {20'h0, vga_r, vga_g, vga_b}, 0);
    chk("rst_tick", 32'(frame_tick), 0);
    chk("rst_row", 32'(row), 0);
    chk("rst_col", 32'(col), 0);
  endtask

  // Monitor: pops one expectation per clock and tracks sync pulse widths.
  int hrun = 0;
  int vrun = 0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        hrun = 0;
        vrun = 0;
      end else begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("hsync", 32'(hsync), 32'(e.hs));
          chk("vsync", 32'(vsync), 32'(e.vs));
          chk("frame_tick", 32'(frame_tick), 32'(e.tick));
          chk("rgb", {20'h0, vga_r, vga_g, vga_b}, {20'h0, e.r, e.g, e.b});
        end
        if (hsync == 1'b0) hrun++;
        else if (hrun > 0) begin
          chk("hsync_width", hrun, HS);
          hrun = 0;
        end
        if (vsync == 1'b0) vrun++;
        else if (vrun > 0) begin
          chk("vsync_width", vrun, VS * HT);
          vrun = 0;
        end
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    k   = 0;

    quiet = 1'b1;
    repeat (HT * VT) step();
    quiet = 1'b0;
    repeat (HT * VT + 7) step();

    // Abort mid-line inside the hsync window of an active line.
    guard = 0;
    while (!((k % HT == AC + HF + 1) && ((k / HT) % VT == 5)) && guard < HT * VT) begin
      step();
      guard++;
    end
    chk("reset_point_reached", guard < HT * VT, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k   = 0;
    repeat (HT * VT + HT) step();

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
